hazard_unit_mc: RTL and testbench



---
 rtl/hazard_unit_mc.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Adds a multi-cycle EX lockout FSM and a saturating stall-cycle counter.
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_src,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mc_start,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic              fstall,
    output logic              dstall,
    output logic              estall,
    output logic              dflush,
    output logic              eflush,
    output logic              mflush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  perf_stall
);

    localparam int MC_CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [MC_CW-1:0] CNT_INIT = MC_CW'(MC_LAT - 2);
    localparam logic FWD = (FWD_EN != 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [MC_CW-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  perf_q, perf_d;
    logic              mc_stall;
    logic              data_hazard;

    // A source hazards only if it is read, non-x0, and matches a producer the
    // pipeline cannot forward from (loads always; everything when FWD is off).
    function automatic logic src_hazard(
        input logic [REG_AW-1:0] rs,
        input logic              use_rs,
        input logic [REG_AW-1:0] erd,
        input logic              ewr,
        input logic              eld,
        input logic [REG_AW-1:0] mrd,
        input logic              mwr
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = (erd == rs);
        mem_hit = (mrd == rs);
        return use_rs && (rs != '0) &&
               ((eld && ex_hit) || (!FWD && ewr && ex_hit) || (!FWD && mwr && mem_hit));
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] mrd,
        input logic              mwr,
        input logic [REG_AW-1:0] wrd,
        input logic              wwr
    );
        if (FWD && mwr && (mrd != '0) && (mrd == rs))      return 2'b10;
        else if (FWD && wwr && (wrd != '0) && (wrd == rs)) return 2'b01;
        else                                               return 2'b00;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mc_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_mc_start) begin
                    mc_stall = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    mc_stall = 1'b1;
                    cnt_d    = cnt_q - MC_CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_hazard =
        src_hazard(id_rs1, id_use_rs1, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write) ||
        src_hazard(id_rs2, id_use_rs2, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write);

    // Every control is forced low while reset is held, even though the FSM
    // state alone would already read IDLE.
    always_comb begin
        fstall  = 1'b0;
        dstall  = 1'b0;
        estall  = 1'b0;
        dflush  = 1'b0;
        eflush  = 1'b0;
        mflush  = 1'b0;
        mc_busy = 1'b0;
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (!rst) begin
            if (mc_stall) begin
                fstall  = 1'b1;
                dstall  = 1'b1;
                estall  = 1'b1;
                mflush  = 1'b1;
                mc_busy = 1'b1;
            end else if (pc_src) begin
                dflush = 1'b1;
                eflush = 1'b1;
            end else if (data_hazard) begin
                fstall = 1'b1;
                dstall = 1'b1;
                eflush = 1'b1;
            end
            fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (fstall && (perf_q != '1)) perf_d = perf_q + CNT_W'(1);
    end

    assign perf_stall = perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: two configurations driven by shared directed vectors,
// checked each cycle against a rule-level model plus hand-computed literals.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       pc_src;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, ex_mc_start;
    logic       mem_reg_write, wb_reg_write;

    logic        a_fs, a_ds, a_es, a_df, a_ef, a_mf, a_busy;
    logic [1:0]  a_fa, a_fb;
    logic [15:0] a_perf;
    logic        b_fs, b_ds, b_es, b_df, b_ef, b_mf, b_busy;
    logic [1:0]  b_fa, b_fb;
    logic [3:0]  b_perf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .FWD_EN(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .pc_src(pc_src),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fstall(a_fs), .dstall(a_ds), .estall(a_es), .dflush(a_df), .eflush(a_ef), .mflush(a_mf),
        .fwd_a(a_fa), .fwd_b(a_fb), .mc_busy(a_busy), .perf_stall(a_perf)
    );

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(2), .FWD_EN(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .pc_src(pc_src),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mc_start(ex_mc_start),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .fstall(b_fs), .dstall(b_ds), .estall(b_es), .dflush(b_df), .eflush(b_ef), .mflush(b_mf),
        .fwd_a(b_fa), .fwd_b(b_fb), .mc_busy(b_busy), .perf_stall(b_perf)
    );

    typedef struct packed {
        logic       fs, ds, es, df, ef, mf;
        logic [1:0] fa, fb;
        logic       busy;
    } ctl_t;

    // Model state: remaining EX cycles of the current multi-cycle op, and stall count.
    int left[2]    = '{0, 0};
    int perf_m[2]  = '{0, 0};
    int lat[2]     = '{4, 2};
    int pmax[2]    = '{65535, 15};
    bit fwdp[2]    = '{1'b1, 1'b0};

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] rs, input logic use_rs,
                                 input logic [4:0] rd, input logic wr);
        return use_rs && wr && (rd != 0) && (rd == rs);
    endfunction

    function automatic logic [1:0] pick(input logic [4:0] rs, input bit fwd);
        if (!fwd) return 2'b00;
        if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
        if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_cycle();
        ctl_t e;
        ctl_t got;
        bit   mc;
        bit   haz;
        int   gp;
        for (int i = 0; i < 2; i++) begin
            e  = '0;
            mc = 1'b0;
            if (rst) begin
                left[i]   = 0;
                perf_m[i] = 0;
            end else begin
                if (left[i] > 0) begin
                    mc = (left[i] > 1);
                    left[i]--;
                end else if (ex_mc_start) begin
                    mc = 1'b1;
                    left[i] = lat[i] - 1;
                end
                haz = reads(id_rs1, id_use_rs1, ex_rd, ex_mem_read) ||
                      reads(id_rs2, id_use_rs2, ex_rd, ex_mem_read) ||
                      (!fwdp[i] && (reads(id_rs1, id_use_rs1, ex_rd, ex_reg_write) ||
                                    reads(id_rs2, id_use_rs2, ex_rd, ex_reg_write) ||
                                    reads(id_rs1, id_use_rs1, mem_rd, mem_reg_write) ||
                                    reads(id_rs2, id_use_rs2, mem_rd, mem_reg_write)));
                if (mc) begin
                    e.fs = 1; e.ds = 1; e.es = 1; e.mf = 1; e.busy = 1;
                end else if (pc_src) begin
                    e.df = 1; e.ef = 1;
                end else if (haz) begin
                    e.fs = 1; e.ds = 1; e.ef = 1;
                end
                e.fa = pick(ex_rs1, fwdp[i]);
                e.fb = pick(ex_rs2, fwdp[i]);
            end
            if (i == 0) begin
                got = {a_fs, a_ds, a_es, a_df, a_ef, a_mf, a_fa, a_fb, a_busy};
                gp  = int'(a_perf);
            end else begin
                got = {b_fs, b_ds, b_es, b_df, b_ef, b_mf, b_fa, b_fb, b_busy};
                gp  = int'(b_perf);
            end
            chk($sformatf("model_ctl_u%0d", i), int'(got), int'(e));
            chk($sformatf("model_perf_u%0d", i), gp, perf_m[i]);
            if (!rst && e.fs && perf_m[i] < pmax[i]) perf_m[i]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        pc_src = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_mc_start = 0; mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    endtask

    initial begin
        rst = 1;
        clr();
        ex_mc_start = 1;
        step();
        chk("rst_busy", a_busy, 0);
        chk("rst_fstall", a_fs, 0);
        chk("rst_perf", a_perf, 0);
        adv();
        rst = 0;
        clr();

        // load-use
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        step();
        chk("lu_fstall", a_fs, 1);
        chk("lu_dstall", a_ds, 1);
        chk("lu_eflush", a_ef, 1);
        chk("lu_estall", a_es, 0);
        adv();
        clr();
        step();
        chk("lu_perf", a_perf, 1);
        chk("lu_release", a_fs, 0);
        adv();

        // x0 and unused source
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        step();
        chk("x0_nostall", a_fs, 0);
        adv();
        clr();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
        step();
        chk("unused_nostall", a_fs, 0);
        adv();

        // branch over hazard
        clr();
        pc_src = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        step();
        chk("br_dflush", a_df, 1);
        chk("br_eflush", a_ef, 1);
        chk("br_fstall", a_fs, 0);
        adv();

        // back-to-back multi-cycle ops
        clr();
        ex_mc_start = 1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("mc4_busy_%0d", k), a_busy, (k % 4 != 3) ? 1 : 0);
            chk($sformatf("mc4_mflush_%0d", k), a_mf, (k % 4 != 3) ? 1 : 0);
            chk($sformatf("mc2_busy_%0d", k), b_busy, (k % 2 == 0) ? 1 : 0);
            adv();
        end
        clr();
        step();
        adv();

        // forwarding priority
        mem_rd = 3; wb_rd = 3; ex_rs1 = 3; ex_rs2 = 3; mem_reg_write = 1; wb_reg_write = 1;
        step();
        chk("fwd_mem_a", a_fa, 2);
        chk("fwd_mem_b", a_fb, 2);
        chk("fwd_off_a", b_fa, 0);
        adv();
        mem_reg_write = 0;
        step();
        chk("fwd_wb_a", a_fa, 1);
        adv();

        // RAW stalls without forwarding
        clr();
        mem_reg_write = 1; mem_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
        step();
        chk("raw_mem_nofwd", b_fs, 1);
        chk("raw_mem_fwd", a_fs, 0);
        adv();
        clr();
        ex_reg_write = 1; ex_rd = 4; id_rs2 = 4; id_use_rs2 = 1;
        step();
        chk("raw_ex_nofwd", b_fs, 1);
        chk("raw_ex_fwd", a_fs, 0);
        adv();
        clr();
        wb_reg_write = 1; wb_rd = 6; id_rs1 = 6; id_use_rs1 = 1;
        step();
        chk("raw_wb_nostall", b_fs, 0);
        adv();

        // async reset mid-BUSY
        clr();
        ex_mc_start = 1;
        step();
        adv();
        ex_mc_start = 0;
        step();
        chk("pre_rst_busy", a_busy, 1);
        adv();
        rst = 1;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_fstall", a_fs, 0);
        chk("arst_mflush", a_mf, 0);
        chk("arst_perf", a_perf, 0);
        step();
        adv();
        rst = 0;
        ex_mc_start = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("restart_busy_%0d", k), a_busy, (k != 3) ? 1 : 0);
            adv();
        end

        // perf counter saturation
        rst = 1;
        clr();
        step();
        adv();
        rst = 0;
        ex_reg_write = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            adv();
        end
        clr();
        step();
        chk("perf_sat", b_perf, 15);
        chk("perf_nostall", a_perf, 0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
